// File: rtl/fine_sync_mul_pkg.sv
// Shared definitions for the fine_sync_mul_pipe signed multiplier pipeline.
// Holds the NUM_STAGE / SHIFT legality limits, the product-width helper and
// the round / saturate helpers that build the final result.
// The helpers work on a wide internal vector (CALC_W bits). The caller
// sign-extends the product into it and truncates the result back down.
package fine_sync_mul_pkg;

    localparam int NUM_STAGE_MIN = 32'sd1;
    localparam int NUM_STAGE_MAX = 32'sd6;
    localparam int CALC_W        = 32'sd256;

    // Full-precision width of a signed a_w x b_w product.
    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Largest legal arithmetic shift for a given pair of operand widths.
    function automatic int shift_max(input int a_w, input int b_w);
        return a_w + b_w - 32'sd1;
    endfunction

    // Arithmetic right shift. With rounding enabled and shift > 0, add half
    // an LSB of the result first, so ties round toward +infinity.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] p,
        input int                       shift,
        input logic                     sat_en
    );
        logic signed [CALC_W-1:0] one;
        one = {{(CALC_W-1){1'b0}}, 1'b1};
        if (sat_en && (shift > 32'sd0)) begin
            return (p + (one <<< (shift - 32'sd1))) >>> shift;
        end else begin
            return p >>> shift;
        end
    endfunction

    // Rounded and shifted value, clamped to a signed dout_w range when
    // saturation is enabled.
    function automatic logic signed [CALC_W-1:0] round_sat_q(
        input logic signed [CALC_W-1:0] p,
        input int                       shift,
        input int                       dout_w,
        input logic                     sat_en
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        one = {{(CALC_W-1){1'b0}}, 1'b1};
        r   = round_shift(p, shift, sat_en);
        hi  = (one <<< (dout_w - 32'sd1)) - one;
        lo  = ~hi;
        if (!sat_en) begin
            return r;
        end else if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end else begin
            return r;
        end
    endfunction

    // Overflow flag matching round_sat_q: high when the value was clamped.
    function automatic logic round_sat_ovf(
        input logic signed [CALC_W-1:0] p,
        input int                       shift,
        input int                       dout_w,
        input logic                     sat_en
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] hi;
        one = {{(CALC_W-1){1'b0}}, 1'b1};
        r   = round_shift(p, shift, sat_en);
        hi  = (one <<< (dout_w - 32'sd1)) - one;
        if (!sat_en) begin
            return 1'b0;
        end else if ((r > hi) || (r < ~hi)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/fine_sync_mul_pipe_stage.sv
// fine_sync_pipe_stage: one valid/ready register slice.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    upstream handshake, with in_data
//   out_valid/out_ready  downstream handshake, with out_data (registered)
// The slice loads whenever it is empty or its content leaves this cycle.
// A held word therefore cannot change while out_valid is high and
// out_ready is low.
module fine_sync_pipe_stage #(
    parameter int WIDTH = 32'sd8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    assign in_ready  = (!valid_r) || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Stage register: load on advance, and clear the valid bit on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/fine_sync_mul_pipe.sv
// fine_sync_mul_pipe: signed multiplier with an elastic valid/ready pipeline.
// Ports:
//   ap_clk, ap_rst       clock and synchronous active-high reset
//   in_valid/in_ready    operand handshake; din0, din1 are signed operands
//   out_valid/out_ready  result handshake; dout is the signed result
//   ovf                  result was clamped (only when saturation is built)
// Build option: define FINE_SYNC_MUL_SAT_EN to round half up before the
// shift and to clamp the result to DOUT_WIDTH. Without it the result wraps
// and ovf is 0.
// The multiply feeds stage 0, and round/saturate feeds the last stage.
// Latency is NUM_STAGE cycles, with one result per cycle.
module fine_sync_mul_pipe
    import fine_sync_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 32'sd36,
    parameter int DIN1_WIDTH = 32'sd36,
    parameter int DOUT_WIDTH = 32'sd72,
    parameter int NUM_STAGE  = 32'sd3,
    parameter int SHIFT      = 32'sd0
)(
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int PROD_W = prod_width(DIN0_WIDTH, DIN1_WIDTH);

`ifdef FINE_SYNC_MUL_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    if ((NUM_STAGE < NUM_STAGE_MIN) || (NUM_STAGE > NUM_STAGE_MAX)) begin : g_bad_num_stage
        $error("fine_sync_mul_pipe: NUM_STAGE out of range 1..6");
    end
    if ((SHIFT < 32'sd0) || (SHIFT > shift_max(DIN0_WIDTH, DIN1_WIDTH))) begin : g_bad_shift
        $error("fine_sync_mul_pipe: SHIFT out of range");
    end
    if ((DIN0_WIDTH < 32'sd1) || (DIN1_WIDTH < 32'sd1) || (DOUT_WIDTH < 32'sd1) ||
        (PROD_W > CALC_W - 32'sd2) || (DOUT_WIDTH > CALC_W - 32'sd1)) begin : g_bad_width
        $error("fine_sync_mul_pipe: operand or result width out of range");
    end

    // v_s[k]/r_s[k] is the handshake into stage k. Index NUM_STAGE is the
    // output port.
    logic [NUM_STAGE:0]       v_s;
    logic [NUM_STAGE:0]       r_s;
    logic signed [PROD_W-1:0] p_s [NUM_STAGE];
    logic signed [CALC_W-1:0] p_ext_s;
    logic [DOUT_WIDTH-1:0]    q_s;
    logic                     ovf_s;
    logic [DOUT_WIDTH:0]      last_in_s;
    logic [DOUT_WIDTH:0]      last_out_s;

    assign v_s[0]         = in_valid;
    assign in_ready       = r_s[0] && (!ap_rst);
    assign r_s[NUM_STAGE] = out_ready;
    assign out_valid      = v_s[NUM_STAGE];

    // The assignment context is PROD_W wide, so the signed product is exact.
    assign p_s[0] = din0 * din1;

    // The size cast keeps the sign, so the product is sign-extended into
    // the wide vector that the round/saturate helpers use.
    assign p_ext_s   = CALC_W'(p_s[NUM_STAGE-1]);
    assign q_s       = DOUT_WIDTH'(round_sat_q(p_ext_s, SHIFT, DOUT_WIDTH, SAT_EN));
    assign ovf_s     = round_sat_ovf(p_ext_s, SHIFT, DOUT_WIDTH, SAT_EN);
    assign last_in_s = {ovf_s, q_s};

    assign dout = last_out_s[DOUT_WIDTH-1:0];
    assign ovf  = last_out_s[DOUT_WIDTH];

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        if (k == NUM_STAGE - 1) begin : g_last
            fine_sync_pipe_stage #(.WIDTH(DOUT_WIDTH + 1)) u_stage (
                .clk       (ap_clk),
                .rst       (ap_rst),
                .in_valid  (v_s[k]),
                .in_data   (last_in_s),
                .in_ready  (r_s[k]),
                .out_valid (v_s[k+1]),
                .out_ready (r_s[k+1]),
                .out_data  (last_out_s)
            );
        end else begin : g_mid
            fine_sync_pipe_stage #(.WIDTH(PROD_W)) u_stage (
                .clk       (ap_clk),
                .rst       (ap_rst),
                .in_valid  (v_s[k]),
                .in_data   (p_s[k]),
                .in_ready  (r_s[k]),
                .out_valid (v_s[k+1]),
                .out_ready (r_s[k+1]),
                .out_data  (p_s[k+1])
            );
        end
    end

endmodule

// File: tb/tb_fine_sync_mul_pipe.sv
// Directed testbench for fine_sync_mul_pipe. It uses four instances:
// defaults, a 16-bit result with shift 4, NUM_STAGE=1, and NUM_STAGE=6.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_fine_sync_mul_pipe;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic a_iv, a_ir, a_ov, a_or, a_ovf;
    logic signed [35:0] a_d0, a_d1;
    logic signed [71:0] a_dout;

    logic b_iv, b_ir, b_ov, b_or, b_ovf;
    logic signed [15:0] b_d0, b_d1, b_dout;

    logic c_iv, c_ir, c_ov, c_or, c_ovf;
    logic signed [7:0]  c_d0, c_d1;
    logic signed [15:0] c_dout;

    logic d_iv, d_ir, d_ov, d_or, d_ovf;
    logic signed [7:0]  d_d0, d_d1;
    logic signed [15:0] d_dout;

    fine_sync_mul_pipe u_a (
        .ap_clk(clk), .ap_rst(rst), .in_valid(a_iv), .in_ready(a_ir),
        .din0(a_d0), .din1(a_d1), .out_valid(a_ov), .out_ready(a_or),
        .dout(a_dout), .ovf(a_ovf));

    fine_sync_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(16),
                         .NUM_STAGE(3), .SHIFT(4)) u_b (
        .ap_clk(clk), .ap_rst(rst), .in_valid(b_iv), .in_ready(b_ir),
        .din0(b_d0), .din1(b_d1), .out_valid(b_ov), .out_ready(b_or),
        .dout(b_dout), .ovf(b_ovf));

    fine_sync_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16),
                         .NUM_STAGE(1), .SHIFT(0)) u_c (
        .ap_clk(clk), .ap_rst(rst), .in_valid(c_iv), .in_ready(c_ir),
        .din0(c_d0), .din1(c_d1), .out_valid(c_ov), .out_ready(c_or),
        .dout(c_dout), .ovf(c_ovf));

    fine_sync_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16),
                         .NUM_STAGE(6), .SHIFT(0)) u_d (
        .ap_clk(clk), .ap_rst(rst), .in_valid(d_iv), .in_ready(d_ir),
        .din0(d_d0), .din1(d_d1), .out_valid(d_ov), .out_ready(d_or),
        .dout(d_dout), .ovf(d_ovf));

    task automatic drain_a();
        a_iv = 1'b0;
        a_or = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid got %0b expected 0", a_ov);
        if (a_ov !== 1'b0) errors++;
        checks++; if (a_dout !== 72'sd0) begin errors++; $display("FAIL reset_dout got %0d expected 0", a_dout); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b expected 0", a_ovf); end
        checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %0b expected 0", a_ir); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %0b expected 1", a_ir); end
    endtask

    task automatic test_basic();
        logic exp_v;
        a_or = 1'b1;
        a_iv = 1'b1;
        a_d0 = -36'sd3;
        a_d1 = 36'sd5;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            a_iv  = 1'b0;
            exp_v = (i == 3) ? 1'b1 : 1'b0;
            checks++;
            if (a_ov !== exp_v) begin
                errors++; $display("FAIL basic_valid cycle %0d got %0b expected %0b", i, a_ov, exp_v);
            end
            if (i == 3) begin
                checks++;
                if (a_dout !== -72'sd15) begin errors++; $display("FAIL basic_dout got %0d expected -15", a_dout); end
                checks++;
                if (a_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b expected 0", a_ovf); end
            end
        end
    endtask

    task automatic test_corner();
        logic signed [71:0] exp_d;
        exp_d = 72'sh400000000000000000;
        a_or = 1'b1;
        a_iv = 1'b1;
        a_d0 = 36'sh800000000;
        a_d1 = 36'sh800000000;
        @(negedge clk);
        a_iv = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL corner_valid got %0b expected 1", a_ov); end
        checks++; if (a_dout !== exp_d) begin errors++; $display("FAIL corner_dout got %0h expected %0h", a_dout, exp_d); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL corner_ovf got %0b expected 0", a_ovf); end
        drain_a();
    endtask

    task automatic test_sat();
        logic signed [15:0] exp0, exp1;
        logic               eovf0;
`ifdef FINE_SYNC_MUL_SAT_EN
        exp0 = 16'sd32767; eovf0 = 1'b1; exp1 = 16'sd5;
`else
        exp0 = -16'sd3036; eovf0 = 1'b0; exp1 = 16'sd4;
`endif
        b_or = 1'b1;
        b_iv = 1'b1; b_d0 = 16'sd1000; b_d1 = 16'sd1000;
        @(negedge clk);
        b_d0 = 16'sd25; b_d1 = 16'sd3;
        @(negedge clk);
        b_iv = 1'b0;
        @(negedge clk);
        checks++; if (b_ov !== 1'b1 || b_dout !== exp0) begin
            errors++; $display("FAIL sat_big got v=%0b d=%0d expected v=1 d=%0d", b_ov, b_dout, exp0);
        end
        checks++; if (b_ovf !== eovf0) begin errors++; $display("FAIL sat_big_ovf got %0b expected %0b", b_ovf, eovf0); end
        @(negedge clk);
        checks++; if (b_ov !== 1'b1 || b_dout !== exp1) begin
            errors++; $display("FAIL sat_round got v=%0b d=%0d expected v=1 d=%0d", b_ov, b_dout, exp1);
        end
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL sat_round_ovf got %0b expected 0", b_ovf); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall_fill();
        logic signed [35:0] p0 [4];
        logic signed [35:0] p1 [4];
        logic signed [71:0] ex [4];
        int acc, cyc;
        p0[0] = 36'sd7;   p1[0] = 36'sd11;   ex[0] = 72'sd77;
        p0[1] = -36'sd4;  p1[1] = 36'sd9;    ex[1] = -72'sd36;
        p0[2] = 36'sd100; p1[2] = -36'sd100; ex[2] = -72'sd10000;
        p0[3] = 36'sd6;   p1[3] = 36'sd6;    ex[3] = 72'sd36;
        acc = 0; cyc = 0;
        a_or = 1'b0;
        a_iv = 1'b1;
        while (acc < 3 && cyc < 20) begin
            a_d0 = p0[acc]; a_d1 = p1[acc];
            #1;
            if (a_ir) acc++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL stall_accepts got %0d expected 3", acc); end
        a_d0 = p0[3]; a_d1 = p1[3];
        #1;
        checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b expected 0", a_ir); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_ov !== 1'b1 || a_dout !== ex[0]) begin
                errors++; $display("FAIL stall_hold cycle %0d got v=%0b d=%0d expected v=1 d=%0d", i, a_ov, a_dout, ex[0]);
            end
            @(negedge clk);
        end
        a_or = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL full_accept_ready got %0b expected 1", a_ir); end
        @(negedge clk);
        a_iv = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (a_ov !== 1'b1 || a_dout !== ex[k]) begin
                errors++; $display("FAIL drain_order idx %0d got v=%0b d=%0d expected v=1 d=%0d", k, a_ov, a_dout, ex[k]);
            end
            @(negedge clk);
        end
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b expected 0", a_ov); end
    endtask

    task automatic test_back_to_back();
        logic signed [35:0] d0_v [10];
        logic signed [35:0] d1_v [10];
        logic signed [71:0] exp_q [$];
        logic signed [71:0] tmp, held;
        logic               stalled;
        logic [63:0]        rnd;
        int sent, got, cyc;
        for (int i = 0; i < 10; i++) begin
            rnd = {$urandom, $urandom};
            d0_v[i] = rnd[35:0];
            d1_v[i] = rnd[63:28];
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 10 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++;
                if (a_ov !== 1'b1 || a_dout !== held) begin
                    errors++; $display("FAIL b2b_stable got v=%0b d=%0d expected v=1 d=%0d", a_ov, a_dout, held);
                end
            end
            a_or = 1'($urandom_range(0, 1));
            a_iv = (sent < 10) ? 1'b1 : 1'b0;
            if (sent < 10) begin
                a_d0 = d0_v[sent]; a_d1 = d1_v[sent];
            end
            #1;
            if (a_iv && a_ir) begin
                tmp = a_d0 * a_d1;
                exp_q.push_back(tmp);
                sent++;
            end
            if (a_ov && a_or) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got d=%0d expected no output", a_dout);
                end else begin
                    tmp = exp_q.pop_front();
                    if (a_dout !== tmp) begin
                        errors++; $display("FAIL b2b_data idx %0d got %0d expected %0d", got, a_dout, tmp);
                    end
                end
                got++;
            end
            stalled = a_ov && !a_or;
            held    = a_dout;
        end
        checks++; if (got != 10) begin errors++; $display("FAIL b2b_count got %0d expected 10", got); end
        @(negedge clk);
        drain_a();
    endtask

    task automatic test_reset_flush();
        int acc, cyc;
        acc = 0; cyc = 0;
        a_or = 1'b0;
        a_iv = 1'b1;
        while (acc < 3 && cyc < 20) begin
            a_d0 = 36'(acc + 2); a_d1 = 36'sd3;
            #1;
            if (a_ir) acc++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL flush_accepts got %0d expected 3", acc); end
        a_iv = 1'b0;
        rst  = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL flush_ready_in_reset got %0b expected 0", a_ir); end
        @(negedge clk);
        rst  = 1'b0;
        a_or = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %0b expected 1", a_ir); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (a_ov !== 1'b0) begin errors++; $display("FAIL flush_no_output cycle %0d got %0b expected 0", i, a_ov); end
            @(negedge clk);
        end
    endtask

    task automatic test_stage_sweep();
        int jc, jd;
        logic signed [15:0] ec, ed;
        c_or = 1'b1; d_or = 1'b1;
        for (int e = 0; e < 12; e++) begin
            c_iv = (e < 4) ? 1'b1 : 1'b0;
            d_iv = c_iv;
            c_d0 = 8'(e + 1); c_d1 = 8'(e + 2);
            d_d0 = c_d0;      d_d1 = c_d1;
            #1;
            if (e < 4) begin
                checks++;
                if (c_ir !== 1'b1 || d_ir !== 1'b1) begin
                    errors++; $display("FAIL sweep_ready edge %0d got c=%0b d=%0b expected 1", e, c_ir, d_ir);
                end
            end
            @(negedge clk);
            jc = e;
            jd = e - 5;
            ec = 16'((jc + 1) * (jc + 2));
            ed = 16'((jd + 1) * (jd + 2));
            checks++;
            if (jc <= 3) begin
                if (c_ov !== 1'b1 || c_dout !== ec) begin
                    errors++; $display("FAIL sweep_n1 edge %0d got v=%0b d=%0d expected v=1 d=%0d", e, c_ov, c_dout, ec);
                end
            end else if (c_ov !== 1'b0) begin
                errors++; $display("FAIL sweep_n1_idle edge %0d got %0b expected 0", e, c_ov);
            end
            checks++;
            if (jd >= 0 && jd <= 3) begin
                if (d_ov !== 1'b1 || d_dout !== ed) begin
                    errors++; $display("FAIL sweep_n6 edge %0d got v=%0b d=%0d expected v=1 d=%0d", e, d_ov, d_dout, ed);
                end
            end else if (d_ov !== 1'b0) begin
                errors++; $display("FAIL sweep_n6_idle edge %0d got %0b expected 0", e, d_ov);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        a_iv = 1'b0; a_or = 1'b1; a_d0 = '0; a_d1 = '0;
        b_iv = 1'b0; b_or = 1'b1; b_d0 = '0; b_d1 = '0;
        c_iv = 1'b0; c_or = 1'b1; c_d0 = '0; c_d1 = '0;
        d_iv = 1'b0; d_or = 1'b1; d_d0 = '0; d_d1 = '0;
        test_reset();
        test_basic();
        test_corner();
        test_sat();
        test_stall_fill();
        test_back_to_back();
        test_reset_flush();
        test_stage_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fine_sync_mul_pipe.md
FINE_SYNC_MUL_PIPE -- requirements
Module: fine_sync_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 36, width of signed operand din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 36, width of signed operand din1.
REQ-003 SHALL have parameter DOUT_WIDTH, default 72, width of signed result.
REQ-004 SHALL have parameter NUM_STAGE, default 3, legal 1..6, register stages from input to output.
REQ-005 SHALL have parameter SHIFT, default 0, legal 0..(DIN0_WIDTH+DIN1_WIDTH-1), arithmetic right shift applied to the full product.
REQ-006 ap_clk  in  1  sole clock, rising edge.
REQ-007 ap_rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  din0/din1 carry a transaction.
REQ-009 in_ready  out  1  block accepts a transaction this cycle.
REQ-010 din0  in  DIN0_WIDTH  signed operand A.
REQ-011 din1  in  DIN1_WIDTH  signed operand B.
REQ-012 out_valid  out  1  dout/ovf carry a result.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 dout  out  DOUT_WIDTH  signed result.
REQ-015 ovf  out  1  result was saturated; qualified by out_valid.

Function
REQ-016 Transfer on in_valid&&in_ready (accept) and out_valid&&out_ready (deliver); one product per accepted pair, strictly in order, none dropped or duplicated.
REQ-017 Full product P = signed(din0)*signed(din1), width DIN0_WIDTH+DIN1_WIDTH, computed without loss; then Q = P >>> SHIFT (arithmetic).
REQ-018 Latency exactly NUM_STAGE cycles from accept to out_valid when out_ready held high; throughput one per cycle sustained.
REQ-019 Each stage holds a valid bit; stage k advances when stage k+1 empty or advancing; last stage advances on out_ready.
REQ-020 in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready permitted, no combinational path from in_valid to out_valid.
REQ-021 out_ready low: pipeline fills, bubbles compress, then in_ready falls; held dout/ovf SHALL remain stable while out_valid high and out_ready low.
REQ-022 Simultaneous accept and deliver with pipeline full SHALL complete both in the same cycle.
REQ-023 Without saturation (REQ-027 off): dout = low DOUT_WIDTH bits of Q if DOUT_WIDTH smaller, else Q sign-extended; ovf = 0.

Reset
REQ-024 ap_rst high at a rising edge SHALL clear all stage valid bits, dout=0, ovf=0, out_valid=0.
REQ-025 in_ready SHALL be 0 while ap_rst high and 1 in the first cycle after deassertion.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; no result from before reset is ever delivered.

Configuration
REQ-027 Macro FINE_SYNC_MUL_SAT_EN defined: if SHIFT>0, add 2^(SHIFT-1) to P before shifting (round half up); clamp Q to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; ovf=1 with a clamped result. Undefined: REQ-023 wrap behaviour, no rounding, ovf tied 0; handshake and latency identical either way.

Structure
REQ-028 Shared package fine_sync_mul_pkg SHALL hold the NUM_STAGE/SHIFT legality limits, product-width localparam function, and the round/saturate function.
REQ-029 One sub-module fine_sync_pipe_stage (valid/ready register stage, data width parameter) SHALL be instantiated NUM_STAGE times via generate; the multiply sits before stage 0, round/saturate before the last stage.
REQ-030 Illegal parameter values SHALL fail elaboration.

Verification
REQ-031 Defaults, out_ready=1: din0=-3, din1=5 accepted at cycle 0 -> dout=-15 at cycle 3, out_valid one cycle.
REQ-032 Defaults: din0=din1=-2^35 -> dout=2^70, no overflow, ovf=0.
REQ-033 Back-to-back 10 random pairs, out_ready toggled 50% random -> outputs match model in order, dout stable while stalled, in_ready low after 3 stalled accepts.
REQ-034 DOUT_WIDTH=16, SHIFT=4, macro defined: din0=din1=1000 -> dout=32767, ovf=1; din0=25, din1=3 -> dout=5 (75/16 rounded), ovf=0; macro undefined: din0=din1=1000 -> dout=(1000000>>>4) mod 2^16 = 62500 as 16-bit = -3036, ovf=0.
REQ-035 ap_rst pulsed one cycle with 3 transactions in flight -> no out_valid afterwards until a new accept; in_ready 0 during reset, 1 next cycle.
REQ-036 NUM_STAGE=1 and 6 sweeps -> latency 1 and 6, full throughput.
